soc_system_onchip_mem_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port 8192 x 64-bit on-chip RAM between the HPS-side bridge (port 0) and the FPGA fabric sensor/logging engine (port 1). It sits between both masters and the RAM's single slave port, and issues at most one access per cycle. It tracks the RAM's one-cycle read latency and steers returning read data to the requester. It also handles the freeze/drain sequence so the RAM can be clock-gated safely.

---
 rtl/soc_system_memarb_pkg.sv | 21 ++
 rtl/soc_system_memarb_pick.sv | 32 +++
 rtl/soc_system_onchip_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_soc_system_onchip_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_memarb_pkg.sv
// Shared types and sizes for the on-chip RAM arbiter.
package soc_system_memarb_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } read_tag_t;

endpackage

// File: rtl/soc_system_memarb_pick.sv
// Two-way request picker; MEMARB_ROUND_ROBIN_EN selects round robin, otherwise port 0 always wins.
module soc_system_memarb_pick
    import soc_system_memarb_pkg::*;
(
    input  logic [1:0] req,
`ifdef MEMARB_ROUND_ROBIN_EN
    input  port_id_t   ptr,
`endif
    output logic [1:0] grant
);

    // One-hot grant from the current requests
    always_comb begin
        grant = 2'b00;
`ifdef MEMARB_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            grant = (ptr == 1'b1) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
`else
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
`endif
    end

endmodule

// File: rtl/soc_system_onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters, with freeze/drain for clock gating.
// Optional feature macro: MEMARB_ROUND_ROBIN_EN (two-way round robin instead of fixed priority).
module soc_system_onchip_mem_arbiter
    import soc_system_memarb_pkg::*;
#(
    parameter int ADDR_W = soc_system_memarb_pkg::ADDR_W,
    parameter int DATA_W = soc_system_memarb_pkg::DATA_W,
    parameter int BE_W   = soc_system_memarb_pkg::BE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    output logic              frozen,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [BE_W-1:0]   p0_byteenable,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [DATA_W-1:0] p0_writedata,
    output logic              p0_waitrequest,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_readdatavalid,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [BE_W-1:0]   p1_byteenable,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [DATA_W-1:0] p1_writedata,
    output logic              p1_waitrequest,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    state_t     state_r, state_next_s;
    read_tag_t  tag_r, tag_next_s;
    logic [1:0] req_s, pick_s, grant_s;
    logic       open_s, gnt_valid_s, gnt_read_s, gnt_write_s;
    port_id_t   sel_s;

    assign req_s = {p1_read | p1_write, p0_read | p0_write};

    // Grants are blocked combinationally in reset, on freeze and outside RUN
    assign open_s  = (state_r == ST_RUN) && !freeze && !reset;
    assign grant_s = open_s ? pick_s : 2'b00;

`ifdef MEMARB_ROUND_ROBIN_EN
    port_id_t ptr_r;

    // Round-robin pointer moves away from the winner of a contested grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if ((grant_s != 2'b00) && (req_s == 2'b11)) begin
            ptr_r <= ~sel_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    soc_system_memarb_pick u_pick (
        .req   (req_s),
        .ptr   (ptr_r),
        .grant (pick_s)
    );
`else
    soc_system_memarb_pick u_pick (
        .req   (req_s),
        .grant (pick_s)
    );
`endif

    // Steer the granted port onto the RAM bus
    always_comb begin
        sel_s          = 1'b0;
        mem_address    = p0_address;
        mem_byteenable = p0_byteenable;
        mem_writedata  = p0_writedata;
        gnt_read_s     = p0_read;
        gnt_write_s    = p0_write;
        if (grant_s[1]) begin
            sel_s          = 1'b1;
            mem_address    = p1_address;
            mem_byteenable = p1_byteenable;
            mem_writedata  = p1_writedata;
            gnt_read_s     = p1_read;
            gnt_write_s    = p1_write;
        end else begin
            sel_s          = 1'b0;
        end
    end

    assign gnt_valid_s    = |grant_s;
    assign mem_chipselect = gnt_valid_s;
    assign mem_write      = gnt_valid_s & gnt_write_s;
    assign p0_waitrequest = ~grant_s[0];
    assign p1_waitrequest = ~grant_s[1];

    // A read combined with a write is treated as a write only, so it gets no return tag
    assign tag_next_s.valid = gnt_valid_s & gnt_read_s & ~gnt_write_s;
    assign tag_next_s.port  = sel_s;

    assign p0_readdatavalid = tag_r.valid && (tag_r.port == 1'b0);
    assign p1_readdatavalid = tag_r.valid && (tag_r.port == 1'b1);
    assign p0_readdata      = p0_readdatavalid ? mem_readdata : {DATA_W{1'b0}};
    assign p1_readdata      = p1_readdatavalid ? mem_readdata : {DATA_W{1'b0}};

    assign mem_clken = (state_r != ST_FROZEN);
    assign frozen    = (state_r == ST_FROZEN);

    // Freeze sequencing; DRAIN is only needed when a read return is still pending
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (freeze) begin
                    state_next_s = tag_r.valid ? ST_DRAIN : ST_FROZEN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!freeze) begin
                    state_next_s = ST_RUN;
                end else if (!tag_r.valid) begin
                    state_next_s = ST_FROZEN;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_FROZEN: begin
                if (!freeze) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FROZEN;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // State and read tag registers; reset drops any in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            tag_r   <= '{valid: 1'b0, port: 1'b0};
        end else begin
            state_r <= state_next_s;
            tag_r   <= tag_next_s;
        end
    end

endmodule

// File: tb/tb_soc_system_onchip_mem_arbiter.sv
// Directed bench for the RAM arbiter with a behavioural RAM, reference memory and read scoreboard.
module tb_soc_system_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, freeze, frozen;
    logic [12:0] p0_address, p1_address, mem_address;
    logic [7:0]  p0_byteenable, p1_byteenable, mem_byteenable;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [63:0] p0_writedata, p1_writedata, p0_readdata, p1_readdata;
    logic        p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
    logic [63:0] mem_writedata, mem_readdata;
    logic        mem_chipselect, mem_write, mem_clken;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ram [0:8191];
    logic [63:0] ref_mem [0:8191];
    int          total  = 0;
    int          passed = 0;

    soc_system_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset), .freeze(freeze), .frozen(frozen),
        .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
        .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
        .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered q output
    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference-model side of an accepted transfer
    task automatic accept(input logic port, input logic rd, input logic wr, input logic [12:0] a,
                          input logic [7:0] be, input logic [63:0] d);
        exp_t e;
        if (wr) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end
        end else if (rd) begin
            e.port = port;
            e.data = ref_mem[a];
            sb.push_back(e);
        end
    endtask

    // One bus cycle: check the expected grant, record accepted transfers, advance past the edge
    task automatic tick(input logic [1:0] exp_gnt, input string tag);
        @(negedge clk); #1;
        check({tag, "_wait0"}, {63'd0, p0_waitrequest}, {63'd0, ~exp_gnt[0]});
        check({tag, "_wait1"}, {63'd0, p1_waitrequest}, {63'd0, ~exp_gnt[1]});
        if (exp_gnt[0]) accept(1'b0, p0_read, p0_write, p0_address, p0_byteenable, p0_writedata);
        if (exp_gnt[1]) accept(1'b1, p1_read, p1_write, p1_address, p1_byteenable, p1_writedata);
        @(posedge clk); #1;
    endtask

    // Read-return monitor: every scoreboard entry must come back at the very next sample
    always @(negedge clk) begin
        exp_t e;
        if (p0_readdatavalid && p1_readdatavalid) begin
            check("rdv_both", 64'd1, 64'd0);
        end else if (p0_readdatavalid || p1_readdatavalid) begin
            if (sb.size() == 0) begin
                check("rdv_unexpected", {62'd0, p1_readdatavalid, p0_readdatavalid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rdv_port", {63'd0, p1_readdatavalid}, {63'd0, e.port});
                check("rdv_data", e.port ? p1_readdata : p0_readdata, e.data);
                check("rdv_other_zero", e.port ? p0_readdata : p1_readdata, 64'd0);
            end
        end else if (sb.size() != 0) begin
            check("rdv_missing", 64'd0, 64'd1);
            sb.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        logic       rr_ptr;
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 64'd0;
            ref_mem[i] = 64'd0;
        end
        reset = 1'b1; freeze = 1'b0;
        p0_address = 13'd0; p0_byteenable = 8'hFF; p0_read = 1'b0; p0_write = 1'b0; p0_writedata = 64'd0;
        p1_address = 13'd0; p1_byteenable = 8'hFF; p1_read = 1'b0; p1_write = 1'b0; p1_writedata = 64'd0;
        #1;
        check("rst_wait0", {63'd0, p0_waitrequest}, 64'd1);
        check("rst_wait1", {63'd0, p1_waitrequest}, 64'd1);
        check("rst_rdv", {62'd0, p1_readdatavalid, p0_readdatavalid}, 64'd0);
        check("rst_cs", {62'd0, mem_chipselect, mem_write}, 64'd0);
        check("rst_clken", {62'd0, mem_clken, frozen}, 64'd2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Port 1 alone: write top address then read it back
        p1_write = 1'b1; p1_address = 13'h1FFF; p1_writedata = 64'h0123_4567_89AB_CDEF;
        tick(2'b10, "p1_write");
        p1_write = 1'b0; p1_read = 1'b1;
        tick(2'b10, "p1_read");
        p1_read = 1'b0;
        tick(2'b00, "p1_idle");

        // Preload distinct data for the contention test
        for (int i = 0; i < 8; i++) begin
            p0_write = 1'b1; p0_address = 13'h100 + 13'(i); p0_writedata = 64'hA0A0_0000_0000_0000 + 64'(i);
            tick(2'b01, "pre0");
            p0_write = 1'b0;
            p1_write = 1'b1; p1_address = 13'h200 + 13'(i); p1_writedata = 64'hB1B1_0000_0000_0000 + 64'(i);
            tick(2'b10, "pre1");
            p1_write = 1'b0;
        end

        // Both ports read every cycle; loser holds its request
        p0_read = 1'b1; p0_address = 13'h100;
        p1_read = 1'b1; p1_address = 13'h200;
        rr_ptr = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            g = rr_ptr ? 2'b10 : 2'b01;
            rr_ptr = ~rr_ptr;
`else
            g = 2'b01;
`endif
            tick(g, "contend");
            if (g[0]) p0_address = p0_address + 13'd1;
            else p1_address = p1_address + 13'd1;
        end
        p0_read = 1'b0;
        tick(2'b10, "contend_tail");
        p1_read = 1'b0;
        tick(2'b00, "contend_idle");

        // Partial byte-lane write, read back from the other port
        p0_write = 1'b1; p0_address = 13'h1FFF; p0_writedata = 64'hFFFF_FFFF_FFFF_FFFF; p0_byteenable = 8'h0F;
        tick(2'b01, "be_write");
        p0_write = 1'b0; p0_byteenable = 8'hFF;
        p1_read = 1'b1; p1_address = 13'h1FFF;
        tick(2'b10, "be_read");
        p1_read = 1'b0;
        tick(2'b00, "be_idle");

        // Read and write together: write only, no return
        p0_read = 1'b1; p0_write = 1'b1; p0_address = 13'h0AA; p0_writedata = 64'hDEAD_BEEF_CAFE_F00D;
        tick(2'b01, "rw_both");
        p0_read = 1'b0; p0_write = 1'b0;
        tick(2'b00, "rw_idle");
        p1_read = 1'b1; p1_address = 13'h0AA;
        tick(2'b10, "rw_check");
        p1_read = 1'b0;
        tick(2'b00, "rw_check_idle");

        // Freeze right after a read accept: return still arrives, frozen two cycles later
        p0_read = 1'b1; p0_address = 13'h103;
        tick(2'b01, "frz_read");
        p0_read = 1'b0; freeze = 1'b1; p1_read = 1'b1; p1_address = 13'h205;
        check("frz_t0_state", {62'd0, mem_clken, frozen}, 64'd2);
        tick(2'b00, "frz_t0");
        check("frz_t1_state", {62'd0, mem_clken, frozen}, 64'd2);
        tick(2'b00, "frz_t1");
        check("frz_t2_state", {62'd0, mem_clken, frozen}, 64'd1);
        tick(2'b00, "frz_t2");
        tick(2'b00, "frz_t3");
        freeze = 1'b0;
        check("frz_release_state", {62'd0, mem_clken, frozen}, 64'd1);
        tick(2'b00, "frz_release");
        check("frz_run_state", {62'd0, mem_clken, frozen}, 64'd2);
        tick(2'b10, "frz_resume");
        p1_read = 1'b0;
        tick(2'b00, "frz_resume_idle");

        // Freeze with nothing in flight: frozen the next cycle
        freeze = 1'b1;
        tick(2'b00, "frz2_t0");
        check("frz2_t1_state", {62'd0, mem_clken, frozen}, 64'd1);
        freeze = 1'b0;
        tick(2'b00, "frz2_t1");
        check("frz2_run_state", {62'd0, mem_clken, frozen}, 64'd2);

        // Reset right after a read accept discards the return
        p0_read = 1'b1; p0_address = 13'h104;
        tick(2'b01, "rst_read");
        reset = 1'b1;
        sb.delete();
        #1;
        check("rstmid_wait", {62'd0, p1_waitrequest, p0_waitrequest}, 64'd3);
        check("rstmid_rdv", {62'd0, p1_readdatavalid, p0_readdatavalid}, 64'd0);
        check("rstmid_rdata", p0_readdata | p1_readdata, 64'd0);
        check("rstmid_cs", {62'd0, mem_chipselect, mem_write}, 64'd0);
        check("rstmid_clken", {62'd0, mem_clken, frozen}, 64'd2);
        @(posedge clk); #1;
        reset = 1'b0; p0_read = 1'b0;
        tick(2'b00, "rstmid_idle");
        p0_read = 1'b1; p0_address = 13'h105;
        tick(2'b01, "post_rst_read");
        p0_read = 1'b0;
        tick(2'b00, "post_rst_idle");
        tick(2'b00, "final_idle");
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
